// File: rtl/conv_pkg.sv
// Shared types and address-width helpers for the time-multiplexed convolution sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  // Width of an address able to index `depth` entries; never narrower than one bit.
  function automatic int addr_w(input int depth);
    if (depth <= 1) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

  function automatic int tap_w(input int ntaps);
    return addr_w(ntaps);
  endfunction

  function automatic int samp_w(input int nsamp);
    return addr_w(nsamp);
  endfunction

  function automatic int out_w(input int nsamp, input int ntaps);
    return addr_w(nsamp + ntaps - 1);
  endfunction

endpackage

// File: rtl/conv_ctrl_delay_line.sv
// Stallable control shift register; selected bits are forced low while the line is held.
module ctrl_delay_line #(
  parameter int                 DEPTH     = 1,
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   HOLD_MASK = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hold,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= {WIDTH{1'b0}};
      end
    end else if (!i_hold) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // Held stages keep their contents so they re-emit once the hold is released.
  always_comb begin
    if (i_hold) begin
      o_q = r_stage[DEPTH-1] & ~HOLD_MASK;
    end else begin
      o_q = r_stage[DEPTH-1];
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Sequences one MAC through y[n] = sum_k h[k]*x[n-k]: issues (n,k) pairs with k inner,
// zero-pads out-of-range taps and strobes accumulator clear/enable and result writes.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int NTAPS  = 20,
  parameter int NSAMP  = 2401,
  parameter int RD_LAT = 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_start,
  input  logic                                  i_stall,
  output logic [conv_pkg::tap_w(NTAPS)-1:0]     o_coef_addr,
  output logic [conv_pkg::samp_w(NSAMP)-1:0]    o_samp_addr,
  output logic                                  o_acc_clr,
  output logic                                  o_acc_en,
  output logic                                  o_res_we,
  output logic [conv_pkg::out_w(NSAMP,NTAPS)-1:0] o_res_addr,
  output logic                                  o_busy,
  output logic                                  o_done
);

  localparam int NOUT   = NSAMP + NTAPS - 1;
  localparam int W_TAP  = tap_w(NTAPS);
  localparam int W_SAMP = samp_w(NSAMP);
  localparam int W_OUT  = out_w(NSAMP, NTAPS);
  localparam int W_DRN  = addr_w(RD_LAT + 1);

  localparam logic [W_TAP-1:0]        K_LAST    = W_TAP'(NTAPS - 1);
  localparam logic [W_OUT-1:0]        N_LAST    = W_OUT'(NOUT - 1);
  localparam logic signed [W_OUT:0]   SAMP_MAX  = (W_OUT+1)'(NSAMP - 1);
  localparam logic [W_DRN-1:0]        DRN_LAST  = W_DRN'(RD_LAT);
  localparam logic [1:0]              ACC_MASK  = 2'b11;
  localparam logic [W_OUT:0]          RES_MASK  = {1'b1, {W_OUT{1'b0}}};

  conv_state_e              r_state;
  conv_state_e              w_state_nxt;
  logic [W_OUT-1:0]         r_n;
  logic [W_TAP-1:0]         r_k;
  logic [W_SAMP-1:0]        r_samp_addr;
  logic                     r_tap_v;
  logic [W_DRN-1:0]         r_drain_cnt;

  logic                     w_accept;
  logic                     w_adv;
  logic                     w_last;
  logic                     w_issuing;
  logic [W_OUT-1:0]         w_n_nxt;
  logic [W_TAP-1:0]         w_k_nxt;
  logic [W_OUT:0]           w_n_ext;
  logic [W_OUT:0]           w_k_ext;
  logic signed [W_OUT:0]    w_diff;
  logic                     w_tap_v_nxt;
  logic [W_SAMP-1:0]        w_samp_nxt;
  logic [1:0]               w_acc_d;
  logic [1:0]               w_acc_q;
  logic [W_OUT:0]           w_res_d;
  logic [W_OUT:0]           w_res_q;
  logic                     w_busy;
  logic                     w_done;

  assign w_accept  = (r_state == ST_IDLE) && i_start;
  assign w_adv     = (r_state == ST_RUN) && !i_stall;
  assign w_issuing = (r_state == ST_RUN);
  assign w_last    = (r_n == N_LAST) && (r_k == K_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!i_stall && w_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!i_stall && (r_drain_cnt == DRN_LAST)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
      ST_RUN, ST_DRAIN: begin
        w_busy = 1'b1;
        w_done = 1'b0;
      end
      ST_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Next (n,k): k runs fastest; the pair returns to (0,0) after the final issue.
  always_comb begin
    w_n_nxt = r_n;
    w_k_nxt = r_k;
    if (w_accept || (w_adv && w_last)) begin
      w_n_nxt = {W_OUT{1'b0}};
      w_k_nxt = {W_TAP{1'b0}};
    end else if (w_adv) begin
      if (r_k == K_LAST) begin
        w_k_nxt = {W_TAP{1'b0}};
        w_n_nxt = r_n + W_OUT'(1);
      end else begin
        w_k_nxt = r_k + W_TAP'(1);
        w_n_nxt = r_n;
      end
    end else begin
      w_n_nxt = r_n;
      w_k_nxt = r_k;
    end
  end

  assign w_n_ext = {1'b0, w_n_nxt};
  assign w_k_ext = (W_OUT+1)'(w_k_nxt);

  always_comb begin
    w_diff      = signed'(w_n_ext - w_k_ext);
    w_tap_v_nxt = !w_diff[W_OUT] && (w_diff <= SAMP_MAX);
    if (w_tap_v_nxt) begin
      w_samp_nxt = w_diff[W_SAMP-1:0];
    end else begin
      w_samp_nxt = {W_SAMP{1'b0}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n         <= {W_OUT{1'b0}};
      r_k         <= {W_TAP{1'b0}};
      r_samp_addr <= {W_SAMP{1'b0}};
      r_tap_v     <= 1'b0;
    end else if (w_accept || w_adv) begin
      r_n         <= w_n_nxt;
      r_k         <= w_k_nxt;
      r_samp_addr <= w_samp_nxt;
      r_tap_v     <= w_tap_v_nxt;
    end
  end

  // Drain counts the non-stalled cycles needed to flush the deepest control stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drain_cnt <= {W_DRN{1'b0}};
    end else if (r_state == ST_DRAIN) begin
      if (!i_stall) begin
        r_drain_cnt <= r_drain_cnt + W_DRN'(1);
      end
    end else begin
      r_drain_cnt <= {W_DRN{1'b0}};
    end
  end

  assign w_acc_d = {w_issuing && (r_k == {W_TAP{1'b0}}), w_issuing && r_tap_v};
  assign w_res_d = {w_issuing && (r_k == K_LAST), r_n};

  ctrl_delay_line #(
    .DEPTH     (RD_LAT),
    .WIDTH     (2),
    .HOLD_MASK (ACC_MASK)
  ) u_acc_dly (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_hold (i_stall),
    .i_d    (w_acc_d),
    .o_q    (w_acc_q)
  );

  ctrl_delay_line #(
    .DEPTH     (RD_LAT + 1),
    .WIDTH     (W_OUT + 1),
    .HOLD_MASK (RES_MASK)
  ) u_res_dly (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_hold (i_stall),
    .i_d    (w_res_d),
    .o_q    (w_res_q)
  );

  assign o_coef_addr = r_k;
  assign o_samp_addr = r_samp_addr;
  assign o_acc_clr   = w_acc_q[1];
  assign o_acc_en    = w_acc_q[0];
  assign o_res_we    = w_res_q[W_OUT];
  assign o_res_addr  = w_res_q[W_OUT-1:0];
  assign o_busy      = w_busy;
  assign o_done      = w_done;

endmodule
